// File: rtl/bcd_result_conv_if.sv
// Handshake bundle between the subtractor, the BCD converter and the display driver.
// Both sides are valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1.
interface bcd_result_conv_if #(
  parameter int IN_W   = 12,
  parameter int DIGITS = 4
);
  logic [IN_W-1:0]     in_data;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] out_bcd;
  logic                out_neg;
  logic [DIGITS-1:0]   out_digit_on;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_bcd, out_neg, out_digit_on, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_bcd, out_neg, out_digit_on, out_valid
  );
endinterface

// File: rtl/bcd_result_conv.sv
// Converts a two's-complement difference to sign + packed BCD using sequential
// double-dabble (one bit per clock), with leading-zero blanking flags for the display.
module bcd_result_conv #(
  parameter int IN_W   = 12,
  parameter int DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  bcd_result_conv_if.slave bus,
  output logic [1:0] state_o
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic              neg_q;
  logic [IN_W-1:0]   mag_q;
  logic [BCD_W-1:0]  scratch_q;
  logic [CNT_W-1:0]  count_q;
  logic [BCD_W-1:0]  out_bcd_q;
  logic              out_neg_q;
  logic [DIGITS-1:0] out_digit_on_q;
  logic              out_valid_q;

  logic [IN_W-1:0]   mag_in;
  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  scratch_d;
  logic [DIGITS-1:0] digit_on_d;
  logic              any_nz;

  // 0x800 negates to itself, which read as unsigned is the wanted 2048.
  assign mag_in = bus.in_data[IN_W-1] ? IN_W'(~bus.in_data + 1'b1) : bus.in_data;

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    scratch_d  = {adj[BCD_W-2:0], mag_q[IN_W-1]};
    any_nz     = 1'b0;
    digit_on_d = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz        = any_nz | (scratch_d[4*i +: 4] != 4'd0);
      digit_on_d[i] = any_nz;
    end
    digit_on_d[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      neg_q          <= 1'b0;
      mag_q          <= '0;
      scratch_q      <= '0;
      count_q        <= '0;
      out_bcd_q      <= '0;
      out_neg_q      <= 1'b0;
      out_digit_on_q <= '0;
      out_valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            neg_q     <= bus.in_data[IN_W-1];
            mag_q     <= mag_in;
            scratch_q <= '0;
            count_q   <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          mag_q     <= mag_q << 1;
          count_q   <= count_q + 1'b1;
          if (count_q == LAST) begin
            out_bcd_q      <= scratch_d;
            out_neg_q      <= neg_q;
            out_digit_on_q <= digit_on_d;
            out_valid_q    <= 1'b1;
            state_q        <= DONE;
          end
        end
        DONE: begin
          // Result registers keep the last value after the handshake.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = rst_n & (state_q == IDLE);
  assign bus.out_bcd      = out_bcd_q;
  assign bus.out_neg      = out_neg_q;
  assign bus.out_digit_on = out_digit_on_q;
  assign bus.out_valid    = out_valid_q;
  assign state_o          = state_q;
endmodule

// File: tb/tb_bcd_result_conv.sv
// Bench for bcd_result_conv: directed cases plus a random stream against an arithmetic reference.
module tb_bcd_result_conv;
  localparam int IN_W   = 12;
  localparam int DIGITS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_o;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [20:0] exp_q[$];

  bcd_result_conv_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus ();

  bcd_result_conv #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {neg, digit_on, bcd} from decimal arithmetic on the signed value.
  function automatic logic [20:0] ref_model(input int v);
    int          m;
    int          rest;
    logic [15:0] bcd;
    logic [3:0]  on;
    m    = (v < 0) ? -v : v;
    rest = m;
    bcd  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd[4*i +: 4] = 4'(rest % 10);
      rest          = rest / 10;
    end
    on = '0;
    for (int i = 0; i < DIGITS; i++) on[i] = (i == 0) || ((m / (10 ** i)) != 0);
    return {(v < 0), on, bcd};
  endfunction

  task automatic send(input int v);
    int guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    bus.in_data  = 12'(v);
    bus.in_valid = 1'b1;
    exp_q.push_back(ref_model(v));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic collect(input int hold);
    int          lat;
    logic [20:0] exp;
    wait_result(lat);
    check("latency", lat, 12);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    check("result", {11'd0, bus.out_neg, bus.out_digit_on, bus.out_bcd}, {11'd0, exp});
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("valid_drop", {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    int v;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_bcd", {16'd0, bus.out_bcd}, 32'd0);
    check("rst_digit_on", {28'd0, bus.out_digit_on}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("idle_state", {30'd0, state_o}, 32'd0);

    // Test 1 and 2
    send(2);     collect(0);
    check("t1_bcd", {16'd0, bus.out_bcd}, 32'h0002);
    check("t1_on", {28'd0, bus.out_digit_on}, 32'b0001);
    send(1023);  collect(1);
    check("t2_bcd", {16'd0, bus.out_bcd}, 32'h1023);
    check("t2_on", {28'd0, bus.out_digit_on}, 32'b1111);
    send(0);     collect(0);
    check("t2_zero", {15'd0, bus.out_neg, bus.out_bcd}, 32'h0000);
    check("t2_zero_on", {28'd0, bus.out_digit_on}, 32'b0001);

    // Test 3: negatives including the most negative input
    send(-1023); collect(2);
    check("t3_neg1023", {15'd0, bus.out_neg, bus.out_bcd}, 32'h11023);
    send(-2048); collect(0);
    check("t3_neg2048", {15'd0, bus.out_neg, bus.out_bcd}, 32'h12048);
    send(-10);   collect(0);
    check("t3_neg10", {15'd0, bus.out_neg, bus.out_bcd}, 32'h10010);
    check("t3_neg10_on", {28'd0, bus.out_digit_on}, 32'b0011);

    // Test 4: backpressure with a pending operand held on the input
    send(123);
    exp_q.delete();
    bus.in_data  = 12'h001;
    bus.in_valid = 1'b1;
    wait_result(lat);
    check("t4_latency", lat, 12);
    repeat (5) begin
      @(negedge clk);
      check("t4_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t4_bcd", {16'd0, bus.out_bcd}, 32'h0123);
      check("t4_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    #1 check("t4_no_bypass", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t4_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    check("t4_in_ready_up", {31'd0, bus.in_ready}, 32'd1);
    check("t4_retained", {16'd0, bus.out_bcd}, 32'h0123);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("t4_accepted", {31'd0, bus.in_ready}, 32'd0);
    exp_q.push_back(ref_model(1));
    collect(0);
    check("t4_second", {16'd0, bus.out_bcd}, 32'h0001);

    // Test 5: random stream with random consumer stalls
    for (int k = 0; k < 20; k++) begin
      v = int'($urandom_range(0, 2046)) - 1023;
      send(v);
      collect(int'($urandom_range(0, 3)));
    end
    check("t5_queue_drained", exp_q.size(), 0);

    // Test 6: asynchronous reset in the middle of a conversion
    send(999); collect(0);
    send(291);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_bcd_clear", {16'd0, bus.out_bcd}, 32'd0);
    check("t6_flags_clear", {26'd0, bus.out_valid, bus.out_neg, bus.out_digit_on}, 32'd0);
    check("t6_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
    send(5); collect(0);
    check("t6_bcd", {16'd0, bus.out_bcd}, 32'h0005);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
